// File: rtl/next_pc_pkg.sv
// rtl/next_pc_pkg.sv - shared state encodings and constants for the next-PC controller
package next_pc_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STALL  = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } pc_state_e;

    localparam logic [63:0] INSN_BYTES           = 64'd4;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

    function automatic logic is_misaligned(input logic [63:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational next-PC candidate selection
// Register-indirect wins over PC-relative, which wins over sequential; all sums wrap mod 2^64.
module pc_target_calc
    import next_pc_pkg::*;
(
    input  logic [63:0] dirout,
    input  logic [63:0] offset,
    input  logic [63:0] reg_target,
    input  logic        reg_branch,
    input  logic        taken,
    output logic [63:0] dirnext
);

    always_comb begin
        dirnext = dirout + INSN_BYTES;
        if (reg_branch) begin
            dirnext = reg_target;
        end else if (taken) begin
            dirnext = dirout + offset;
        end
    end

endmodule

// File: rtl/next_pc_controller.sv
// rtl/next_pc_controller.sv - program counter sequencer with stall, halt and misalignment fault
// HALTED and FAULT are terminal; only rst leaves them.
module next_pc_controller
    import next_pc_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch,
    input  logic             zero,
    input  logic             uncond,
    input  logic             reg_branch,
    input  logic [63:0]      offset,
    input  logic [63:0]      reg_target,
    output logic [63:0]      dirout,
    output logic [63:0]      dirnext,
    output logic             fetch_valid,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] insn_count
);

    pc_state_e        state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             taken;

    assign taken = uncond | (branch & zero);

    pc_target_calc u_target (
        .dirout     (pc_q),
        .offset     (offset),
        .reg_target (reg_target),
        .reg_branch (reg_branch),
        .taken      (taken),
        .dirnext    (dirnext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (stall) begin
                    state_d = ST_STALL;
                end else if (is_misaligned(dirnext)) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    pc_d  = dirnext;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Branch inputs are ignored while stalled; resuming re-evaluates them in RUN.
            ST_STALL: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (!stall) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign dirout      = pc_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign fault       = fault_q;
    assign state       = state_q;
    assign insn_count  = cnt_q;

endmodule

// File: tb/tb_next_pc_controller.sv
// tb/tb_next_pc_controller.sv - randomized and directed bench for next_pc_controller
module tb_next_pc_controller;

    localparam logic [63:0] RV    = 64'h400000;
    localparam int          CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall, halt, branch, zero, uncond, reg_branch;
    logic [63:0]      offset, reg_target;
    logic [63:0]      dirout, dirnext;
    logic             fetch_valid, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] insn_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int               m_st;
    logic [63:0]      m_pc;
    logic [CNT_W-1:0] m_cnt;
    logic             m_fault;

    next_pc_controller #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .branch      (branch),
        .zero        (zero),
        .uncond      (uncond),
        .reg_branch  (reg_branch),
        .offset      (offset),
        .reg_target  (reg_target),
        .dirout      (dirout),
        .dirnext     (dirnext),
        .fetch_valid (fetch_valid),
        .fault       (fault),
        .state       (state),
        .insn_count  (insn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_next(input logic [63:0] pc);
        if (reg_branch) return reg_target;
        if (uncond || (branch && zero)) return pc + offset;
        return pc + 64'd4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st    <= 0;
            m_pc    <= RV;
            m_cnt   <= '0;
            m_fault <= 1'b0;
        end else if (m_st == 0) begin
            m_st <= 1;
        end else if (m_st == 1) begin
            if (halt) m_st <= 3;
            else if (stall) m_st <= 2;
            else if (model_next(m_pc) % 4 != 0) begin
                m_st    <= 4;
                m_fault <= 1'b1;
            end else begin
                m_pc  <= model_next(m_pc);
                m_cnt <= m_cnt + 1'b1;
            end
        end else if (m_st == 2) begin
            if (halt) m_st <= 3;
            else if (!stall) m_st <= 1;
        end
    end

    always @(negedge clk) begin
        chk("state", 64'(state), 64'(m_st));
        chk("dirout", dirout, m_pc);
        chk("dirnext", dirnext, model_next(m_pc));
        chk("fetch_valid", 64'(fetch_valid), 64'(m_st == 1));
        chk("fault", 64'(fault), 64'(m_fault));
        chk("insn_count", 64'(insn_count), 64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; branch = 0; zero = 0; uncond = 0; reg_branch = 0;
        offset = 64'h0; reg_target = 64'h0;
    endtask

    task automatic jump_to(input logic [63:0] tgt);
        reg_branch = 1; reg_target = tgt;
        tick();
        reg_branch = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        tick(); tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_dirout", dirout, 64'h400000);
        chk("rst_cnt", 64'(insn_count), 64'd0);
        chk("rst_fv", 64'(fetch_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);

        rst = 0;
        #1;
        chk("boot_state", 64'(state), 64'd0);
        tick();
        chk("run_dirout0", dirout, 64'h400000);
        chk("run_fv", 64'(fetch_valid), 64'd1);
        tick();
        chk("run_dirout1", dirout, 64'h400004);
        tick();
        chk("run_dirout2", dirout, 64'h400008);
        chk("run_cnt2", 64'(insn_count), 64'd2);

        jump_to(64'h1000);
        chk("jump_1000", dirout, 64'h1000);
        branch = 1; zero = 1; offset = 64'hFFFF_FFFF_FFFF_FFF8;
        #1;
        chk("dirnext_taken", dirnext, 64'hFF8);
        tick();
        chk("cbz_taken", dirout, 64'hFF8);
        branch = 0;
        jump_to(64'h1000);
        branch = 1; zero = 0;
        tick();
        chk("cbz_not_taken", dirout, 64'h1004);
        branch = 0;

        jump_to(64'h10);
        uncond = 1; offset = 64'h40; stall = 1;
        tick(); tick(); tick();
        chk("stall_state", 64'(state), 64'd2);
        chk("stall_pc", dirout, 64'h10);
        chk("stall_fv", 64'(fetch_valid), 64'd0);
        chk("stall_cnt", 64'(insn_count), 64'd7);
        stall = 0;
        tick();
        chk("unstall_state", 64'(state), 64'd1);
        chk("unstall_pc", dirout, 64'h10);
        tick();
        chk("uncond_pc", dirout, 64'h50);
        chk("uncond_cnt", 64'(insn_count), 64'd8);
        uncond = 0; offset = 64'h0;

        for (int i = 0; i < 20 && insn_count != 4'd15; i++) tick();
        chk("cnt_max", 64'(insn_count), 64'd15);
        tick();
        chk("cnt_wrap", 64'(insn_count), 64'd0);

        jump_to(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("pc_wrap", dirout, 64'h0);

        jump_to(64'h2000);
        reg_branch = 1; reg_target = 64'h3002; branch = 1; zero = 1; uncond = 1;
        tick();
        chk("fault_state", 64'(state), 64'd4);
        chk("fault_pc", dirout, 64'h2000);
        chk("fault_flag", 64'(fault), 64'd1);
        chk("fault_fv", 64'(fetch_valid), 64'd0);
        reg_target = 64'h4000;
        tick();
        chk("fault_sticky", 64'(state), 64'd4);
        idle_inputs();

        #1 rst = 1;
        #1;
        chk("async_state", 64'(state), 64'd0);
        chk("async_pc", dirout, 64'h400000);
        chk("async_fault", 64'(fault), 64'd0);
        #1 rst = 0;
        tick();
        halt = 1; stall = 1;
        tick();
        chk("halt_over_stall", 64'(state), 64'd3);
        halt = 0; stall = 0;
        tick();
        chk("halted_terminal", 64'(state), 64'd3);
        chk("halted_pc", dirout, 64'h400000);

        rst = 1; tick(); rst = 0;
        tick();
        stall = 1;
        tick();
        halt = 1;
        tick();
        chk("stall_to_halt", 64'(state), 64'd3);
        idle_inputs();

        for (int i = 0; i < 3000; i++) begin
            rst        = (m_st >= 3) || ($urandom_range(0, 199) == 0);
            halt       = ($urandom_range(0, 99) < 2);
            stall      = ($urandom_range(0, 99) < 15);
            branch     = 1'($urandom);
            zero       = 1'($urandom);
            uncond     = ($urandom_range(0, 3) == 0);
            reg_branch = ($urandom_range(0, 7) == 0);
            offset     = {{46{1'b0}}, 16'($urandom), 2'b00};
            if ($urandom_range(0, 1) == 1) offset = -offset;
            if ($urandom_range(0, 31) == 0) offset[1:0] = 2'($urandom);
            reg_target = {32'($urandom), 30'($urandom), 2'b00};
            if ($urandom_range(0, 15) == 0) reg_target[1:0] = 2'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_controller.md
NEXT_PC_CONTROLLER -- requirements
Module: next_pc_controller

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 64'h0, PC loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 32, width of the instruction counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  in  1  hold PC this cycle.
REQ-006 SHALL have port halt  in  1  stop sequencing.
REQ-007 SHALL have port branch  in  1  conditional branch (CBZ-type) in current instruction.
REQ-008 SHALL have port zero  in  1  ALU zero flag qualifying branch.
REQ-009 SHALL have port uncond  in  1  unconditional PC-relative branch.
REQ-010 SHALL have port reg_branch  in  1  register-indirect branch.
REQ-011 SHALL have port offset  in  64  sign-extended byte offset, already shifted.
REQ-012 SHALL have port reg_target  in  64  absolute target for reg_branch.
REQ-013 SHALL have port dirout  out  64  current PC.
REQ-014 SHALL have port dirnext  out  64  combinational next-PC candidate.
REQ-015 SHALL have port fetch_valid  out  1  dirout is a valid fetch address this cycle.
REQ-016 SHALL have port fault  out  1  sticky misaligned-target flag.
REQ-017 SHALL have port state  out  3  current FSM state encoding.
REQ-018 SHALL have port insn_count  out  CNT_W  PC-advance counter.

Function
REQ-019 SHALL implement states BOOT=0, RUN=1, STALL=2, HALTED=3, FAULT=4.
REQ-020 SHALL go BOOT->RUN unconditionally one cycle after rst deasserts; fetch_valid=0 in BOOT.
REQ-021 SHALL compute taken = uncond | (branch & zero).
REQ-022 SHALL select dirnext by priority: reg_branch -> reg_target; taken -> dirout+offset; else dirout+4.
REQ-023 SHALL perform all additions modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).
REQ-024 In RUN, SHALL evaluate inputs by priority: halt > stall > misaligned > advance.
REQ-025 In RUN with halt=1, SHALL go HALTED; PC and insn_count hold.
REQ-026 In RUN with stall=1, SHALL go STALL; PC and insn_count hold.
REQ-027 In RUN with dirnext[1:0]!=0, SHALL go FAULT, hold PC, set fault=1.
REQ-028 In RUN otherwise, SHALL load dirout<=dirnext and increment insn_count (wraps at 2^CNT_W).
REQ-029 In STALL, SHALL ignore branch inputs; halt=1 -> HALTED; stall=0 -> RUN; else remain.
REQ-030 fetch_valid SHALL be 1 only in RUN.
REQ-031 HALTED and FAULT SHALL be terminal until rst; fault stays 1 in FAULT.
REQ-032 Simultaneous reg_branch and taken SHALL resolve to reg_target with no error.

Reset
REQ-033 rst=1 SHALL immediately force state=BOOT, dirout=RESET_VECTOR, insn_count=0, fault=0, fetch_valid=0.
REQ-034 rst asserted mid-operation (any state) SHALL abort and apply REQ-033 without waiting for clk.

Structure
REQ-035 Package next_pc_pkg SHALL hold the state encodings, INSN_BYTES=4 and default RESET_VECTOR.
REQ-036 Target arithmetic SHALL live in combinational sub-module pc_target_calc (inputs dirout, offset, reg_target, selects; output dirnext).
REQ-037 Block SHALL be 120-400 lines RTL, no memories, one clock domain.

Verification
REQ-038 Reset RESET_VECTOR=64'h400000, release rst, 3 idle cycles -> dirout 400000, 400000(BOOT), 400004, 400008; insn_count=2.
REQ-039 At PC=64'h1000, branch=1, zero=1, offset=-8 -> next dirout=64'hFF8; with zero=0 -> 64'h1004.
REQ-040 At PC=64'h2000, reg_branch=1, reg_target=64'h3002 -> state FAULT, dirout holds 2000, fault=1, fetch_valid=0.
REQ-041 stall=1 for 3 cycles at PC=64'h10 with uncond=1 -> PC holds 10, fetch_valid=0, insn_count unchanged; stall drop -> RUN.
REQ-042 PC=64'hFFFF_FFFF_FFFF_FFFC, sequential -> dirout=0; insn_count at 2^CNT_W-1 advancing -> 0.
REQ-043 halt and stall together in RUN -> HALTED; rst pulse between clock edges -> immediate BOOT, dirout=RESET_VECTOR.
